// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Provides:
//   - state_e    : FSM state encoding (STATE_W bits)
//   - OP_*       : supported opcode values
//   - aluop_e    : ALU operation class requested by the FSM
//   - ALUC_*     : aluControl codes seen by the shared ALU
//   - imm_src_of : immediate-format select derived from the opcode
package rv_mc_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  // Immediate format: 00 I, 01 S, 10 B, 11 J. Unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] sel;
    case (op)
      OP_SW:   sel = 2'b01;
      OP_BEQ:  sel = 2'b10;
      OP_JAL:  sel = 2'b11;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_deco.sv
// alu_deco: ALU-control decoder shared with the single-cycle core.
// Ports:
//   op         in  opcode (only op[5] matters: separates R-type from I-type)
//   f3         in  funct3
//   f7         in  funct7 (only f7[5] matters: sub vs add)
//   aluOp      in  operation class from the controller (add / sub / funct)
//   aluControl out ALU operation code
module alu_deco
  import rv_mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic [1:0] aluOp,
  output logic [2:0] aluControl
);

  // Remaining opcode/funct7 bits are not needed for this instruction subset.
  logic unused_bits;
  assign unused_bits = ^{op[6], op[4:0], f7[6], f7[4:0]};

  always_comb begin
    aluControl = ALUC_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (f3)
          // Only R-type carries a real funct7; addi must never become sub.
          3'b000:  aluControl = (op[5] & f7[5]) ? ALUC_SUB : ALUC_ADD;
          3'b010:  aluControl = ALUC_SLT;
          3'b110:  aluControl = ALUC_OR;
          3'b111:  aluControl = ALUC_AND;
          default: aluControl = ALUC_ADD;
        endcase
      end
      default: aluControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle RV32I core.
// Sequences a shared ALU, unified instruction/data memory and register file
// over 3-5 cycles per instruction (lw, sw, R-type, I-type ALU, beq, jal).
// mem_ready stalls fetch, load and store until memory completes.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   op, f3, f7      instruction fields from the IR
//   zero            ALU zero flag (branch decision)
//   mem_ready       memory access completes this cycle
//   pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
//   immSrc, regWrite, aluControl   datapath controls
//   illegal_op      one-cycle pulse in DECODE on an unknown opcode
module multicycle_ctrl
  import rv_mc_pkg::*;
#(
  parameter int OP_W = 7,
  parameter int ST_W = rv_mc_pkg::STATE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pcWrite,
  output logic            adrSrc,
  output logic            memWrite,
  output logic            irWrite,
  output logic [1:0]      resultSrc,
  output logic [1:0]      aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [1:0]      immSrc,
  output logic            regWrite,
  output logic [2:0]      aluControl,
  output logic            illegal_op
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  state_e          state;
  aluop_e          alu_op;

  // Encodings 12..15 fall into the case default and recover to FETCH.
  assign state = state_e'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    regWrite   = 1'b0;
    illegal_op = 1'b0;
    alu_op     = ALUOP_ADD;
    immSrc     = imm_src_of(op);

    case (state)
      FETCH: begin
        // PC+4 computed on the ALU and written straight back to the PC.
        resultSrc = 2'b10;
        aluSrcB   = 2'b10;
        irWrite   = mem_ready;
        pcWrite   = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // OldPC + imm: branch/jump target parked in ALUOut.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default: begin
            state_d    = TRAP;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        aluSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regWrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        aluSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        pcWrite = zero;
        state_d = FETCH;
      end
      JAL: begin
        // PC <- target from ALUOut while the ALU forms OldPC+4 for rd.
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset forces every enable low immediately, so an aborted instruction
    // cannot complete a write while rst_n is held.
    if (!rst_n) begin
      pcWrite    = 1'b0;
      adrSrc     = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      resultSrc  = 2'b00;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b10;
      immSrc     = 2'b00;
      regWrite   = 1'b0;
      illegal_op = 1'b0;
      alu_op     = ALUOP_ADD;
    end
  end

  alu_deco u_alu_deco (
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .aluOp      (alu_op),
    .aluControl (aluControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction reference model
// expands each instruction into its expected sequence of control steps.
module tb_multicycle_ctrl;

  localparam logic [6:0] L_LW  = 7'b0000011;
  localparam logic [6:0] L_SW  = 7'b0100011;
  localparam logic [6:0] L_R   = 7'b0110011;
  localparam logic [6:0] L_I   = 7'b0010011;
  localparam logic [6:0] L_BEQ = 7'b1100011;
  localparam logic [6:0] L_JAL = 7'b1101111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       regw;
    logic [2:0] aluc;
    logic       ill;
  } outs_t;

  typedef struct {
    outs_t e;
    outs_t m;
    bit    waits;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero;
  logic       mem_ready;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal_op;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;

  int    total = 0;
  int    bad   = 0;
  step_t q[$];
  outs_t rst_vec;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(7), .ST_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .resultSrc  (resultSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .immSrc     (immSrc),
    .regWrite   (regWrite),
    .aluControl (aluControl),
    .illegal_op (illegal_op)
  );

  function automatic outs_t get_outs();
    outs_t t;
    t.pcw  = pcWrite;
    t.adr  = adrSrc;
    t.memw = memWrite;
    t.irw  = irWrite;
    t.res  = resultSrc;
    t.sa   = aluSrcA;
    t.sb   = aluSrcB;
    t.imm  = immSrc;
    t.regw = regWrite;
    t.aluc = aluControl;
    t.ill  = illegal_op;
    return t;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == L_SW)  return 2'b01;
    if (o == L_BEQ) return 2'b10;
    if (o == L_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_ref(input logic [6:0] o, input logic [2:0] f3v,
                                           input logic [6:0] f7v);
    case (f3v)
      3'b000:  return (o == L_R && f7v[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void push(input outs_t e, input outs_t m, input bit w);
    step_t s;
    s.e = e;
    s.m = m;
    s.waits = w;
    q.push_back(s);
  endfunction

  // Expand one instruction into its expected control steps. Masks select
  // the fields that are defined for each step; enables are always checked.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3v,
                                input logic [6:0] f7v, input logic z);
    outs_t e, m, bm;
    logic [1:0] im;
    logic       legal;
    q.delete();
    im    = imm_ref(o);
    legal = (o == L_LW) || (o == L_SW) || (o == L_R) || (o == L_I) ||
            (o == L_BEQ) || (o == L_JAL);
    bm = '0; bm.pcw = 1; bm.memw = 1; bm.irw = 1; bm.regw = 1; bm.ill = 1; bm.imm = 2'b11;
    // fetch
    e = '0; e.imm = im; e.pcw = 1; e.irw = 1; e.res = 2'b10; e.sb = 2'b10;
    m = bm; m.adr = 1; m.res = '1; m.sa = '1; m.sb = '1; m.aluc = '1;
    push(e, m, 1);
    // decode
    e = '0; e.imm = im; e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal;
    m = bm; m.sa = '1; m.sb = '1; m.aluc = '1;
    push(e, m, 0);
    if (!legal) return;
    if (o == L_LW || o == L_SW) begin
      e = '0; e.imm = im; e.sa = 2'b10; e.sb = 2'b01;
      m = bm; m.sa = '1; m.sb = '1; m.aluc = '1;
      push(e, m, 0);
      if (o == L_LW) begin
        e = '0; e.imm = im; e.adr = 1;
        m = bm; m.adr = 1; m.res = '1;
        push(e, m, 1);
        e = '0; e.imm = im; e.res = 2'b01; e.regw = 1;
        m = bm; m.res = '1;
        push(e, m, 0);
      end else begin
        e = '0; e.imm = im; e.adr = 1; e.memw = 1;
        m = bm; m.adr = 1;
        push(e, m, 1);
      end
      return;
    end
    if (o == L_BEQ) begin
      e = '0; e.imm = im; e.sa = 2'b10; e.sb = 2'b00; e.aluc = 3'b001; e.pcw = z;
      m = bm; m.sa = '1; m.sb = '1; m.aluc = '1; m.res = '1;
      push(e, m, 0);
      return;
    end
    if (o == L_JAL) begin
      e = '0; e.imm = im; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1;
      m = bm; m.sa = '1; m.sb = '1; m.aluc = '1; m.res = '1;
      push(e, m, 0);
    end else begin
      e = '0; e.imm = im; e.sa = 2'b10; e.sb = (o == L_R) ? 2'b00 : 2'b01;
      e.aluc = funct_ref(o, f3v, f7v);
      m = bm; m.sa = '1; m.sb = '1; m.aluc = '1;
      push(e, m, 0);
    end
    // register write-back of ALUOut
    e = '0; e.imm = im; e.regw = 1;
    m = bm; m.res = '1;
    push(e, m, 0);
  endfunction

  // Drive one instruction through the DUT, one expected step per cycle,
  // inserting fst fetch-stall and mst memory-stall cycles.
  task automatic run_instr(input string nm, input logic [31:0] w, input logic z,
                           input int fst, input int mst);
    outs_t got, ex;
    int    st;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; zero = z;
    build(w[6:0], w[14:12], w[31:25], z);
    foreach (q[i]) begin
      st = q[i].waits ? ((i == 0) ? fst : mst) : 0;
      for (int c = 0; c <= st; c++) begin
        ex = q[i].e;
        if (c < st) begin
          mem_ready = 1'b0;
          ex.pcw = 1'b0;
          ex.irw = 1'b0;
        end else begin
          mem_ready = q[i].waits ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        got = get_outs();
        total++;
        if ((got & q[i].m) !== (ex & q[i].m)) begin
          bad++;
          $display("FAIL %s step%0d cyc%0d: got=%h want=%h mask=%h", nm, i, c, got, ex, q[i].m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    op = L_R; f3 = 3'b000; f7 = 7'h20;
    #1;
    total++;
    if (get_outs() !== rst_vec) begin
      bad++;
      $display("FAIL reset_t0: got=%h want=%h", get_outs(), rst_vec);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (get_outs() !== rst_vec) begin
        bad++;
        $display("FAIL reset_hold%0d: got=%h want=%h", k, get_outs(), rst_vec);
      end
      mem_ready = ~mem_ready;
      op = (k == 1) ? L_BEQ : L_JAL;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr("post_reset_addi", 32'h00508193, 1'b0, 2, 0);
  endtask

  task automatic test_alu_ops();
    run_instr("add",  32'h002081B3, 1'b0, 0, 0);
    run_instr("sub",  32'h402081B3, 1'b1, 0, 0);
    run_instr("slt",  32'h0020A1B3, 1'b0, 1, 0);
    run_instr("or",   32'h0020E1B3, 1'b0, 0, 0);
    run_instr("and",  32'h0020F1B3, 1'b0, 0, 0);
    run_instr("sll",  32'h402091B3, 1'b0, 0, 0);
    run_instr("addi", 32'h40008193, 1'b0, 0, 0);
    run_instr("ori",  32'h0050E193, 1'b0, 0, 0);
  endtask

  task automatic test_load_store();
    run_instr("lw_stall3", 32'h0000A183, 1'b0, 0, 3);
    run_instr("lw_fast",   32'h0040A183, 1'b1, 1, 0);
    run_instr("sw_stall2", 32'h0030A023, 1'b0, 0, 2);
    run_instr("sw_fast",   32'h0030A223, 1'b1, 0, 0);
  endtask

  task automatic test_branch_jump();
    run_instr("beq_taken",    32'h00208463, 1'b1, 0, 0);
    run_instr("beq_nottaken", 32'h00208463, 1'b0, 0, 0);
    run_instr("jal",          32'h008000EF, 1'b0, 0, 0);
    run_instr("jal_after",    32'h002081B3, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [6:0]  ops [6];
    ops[0] = L_LW; ops[1] = L_SW; ops[2] = L_R; ops[3] = L_I; ops[4] = L_BEQ; ops[5] = L_JAL;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 5)];
      run_instr("rand", w, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_reset();
    op = L_SW; f3 = 3'b010; f7 = 7'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (memWrite !== 1'b1) begin
      bad++;
      $display("FAIL midrst_memw_before: got=%b want=1", memWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (get_outs() !== rst_vec) begin
      bad++;
      $display("FAIL midrst_async: got=%h want=%h", get_outs(), rst_vec);
    end
    @(posedge clk); #1;
    total++;
    if (memWrite !== 1'b0) begin
      bad++;
      $display("FAIL midrst_memw_edge: got=%b want=0", memWrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({irWrite, pcWrite, memWrite, regWrite} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_fetch_idle: got=%b want=0000", {irWrite, pcWrite, memWrite, regWrite});
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({irWrite, pcWrite, memWrite} !== 3'b110) begin
      bad++;
      $display("FAIL midrst_fetch_ready: got=%b want=110", {irWrite, pcWrite, memWrite});
    end
    @(posedge clk); #1;
    do_reset();
    run_instr("after_midrst", 32'h402081B3, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    logic [31:0] bad_words [2];
    bad_words[0] = 32'h00000000;
    bad_words[1] = 32'h0000007F;
    for (int t = 0; t < 2; t++) begin
      run_instr("illegal", bad_words[t], 1'b0, t, 0);
      for (int k = 0; k < 6; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        total++;
        if ({pcWrite, memWrite, irWrite, regWrite, illegal_op} !== 5'b00000) begin
          bad++;
          $display("FAIL trap_hold%0d: got=%b want=00000", k,
                   {pcWrite, memWrite, irWrite, regWrite, illegal_op});
        end
        @(posedge clk); #1;
      end
      do_reset();
      run_instr("after_trap", 32'h00208463, 1'b1, 0, 0);
    end
  endtask

  initial begin
    rst_vec = '0;
    rst_vec.sb = 2'b10;
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch_jump();
    test_random();
    test_mid_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
